// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, entry type and helpers for the fetch front end.
// Imported by the prefetch buffer and its FIFO.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } fetch_entry_t;

  function automatic logic [PC_W-1:0] word_align(
    input logic [PC_W-1:0] a
  );
    return {a[PC_W-1:2], 2'b00};
  endfunction

  function automatic logic [31:0] sat_inc32(
    input logic [31:0] v,
    input logic        en
  );
    if (en && (v != 32'hFFFF_FFFF)) return v + 32'd1;
    return v;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two synchronous FIFO with clear and occupancy count.
// Head data is read combinationally; writes land on the clock edge.
module sync_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_pop,
  input  logic                   i_clear,
  output logic [WIDTH-1:0]       o_rdata,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_full;
  logic             w_wr;
  logic             w_rd;

  assign o_empty = (r_count == '0);
  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_wr    = i_push & ~w_full;
  assign w_rd    = i_pop & ~o_empty;
  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;

  // Pointer and occupancy bookkeeping; clear wins over push and pop.
  always_ff @(posedge clk) begin
    if (!rst_n || i_clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + AW'(1);
      if (w_rd) r_rptr <= r_rptr + AW'(1);
      unique case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents are meaningless outside the valid window.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= i_wdata;
  end

  // Upstream credit accounting must never let a push meet a full buffer.
  always_ff @(posedge clk) begin
    if (rst_n && !i_clear) assert (!(i_push && w_full));
  end

endmodule

// File: rtl/fetch_prefetch_buffer.sv
// fetch_prefetch_buffer: fetch PC owner, imem requester and instruction buffer.
// Optional FETCH_PERF_EN adds saturating pop/flush/starve counters.
module fetch_prefetch_buffer
  import fetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               stall,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_flushed,
  output logic [31:0]        perf_starved
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [PC_W-1:0] r_fetch_pc;
  logic [PC_W-1:0] r_resp_pc;
  logic [CW-1:0]   r_outst;
  logic [CW-1:0]   r_drop;

  logic [CW-1:0]   w_cnt;
  logic [CW:0]     w_credit;
  logic [PC_W-1:0] w_target;
  logic            w_grant;
  logic            w_discard;
  logic            w_push;
  logic            w_pop;
  logic            w_empty;
  fetch_entry_t    w_wentry;
  fetch_entry_t    w_head;

  assign w_target  = word_align(redirect_pc);
  assign w_credit  = {1'b0, w_cnt} + {1'b0, r_outst};
  assign imem_req  = rst & ~redirect & (w_credit < (CW+1)'(DEPTH));
  assign imem_addr = r_fetch_pc;
  assign w_grant   = imem_req & imem_gnt;

  assign w_discard = imem_rvalid & (r_drop != '0);
  assign w_push    = imem_rvalid & ~w_discard & ~redirect;
  assign w_wentry  = '{instr: imem_rdata, pc: r_resp_pc};

  assign instr_valid = rst & ~w_empty;
  assign w_pop       = instr_valid & ~stall & ~redirect;
  assign instr       = instr_valid ? w_head.instr : NOP_INSTR;
  assign instr_pc    = instr_valid ? w_head.pc : '0;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_push  (w_push),
    .i_wdata (w_wentry),
    .i_pop   (w_pop),
    .i_clear (redirect),
    .o_rdata (w_head),
    .o_count (w_cnt),
    .o_empty (w_empty)
  );

  // Fetch PC, response PC tag, in-flight and discard bookkeeping.
  // outst already covers earlier discards, so a redirect marks every
  // response still in flight after this cycle as stale.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_outst    <= '0;
      r_drop     <= '0;
    end else begin
      r_outst <= r_outst + CW'(w_grant) - CW'(imem_rvalid);
      if (redirect) begin
        r_fetch_pc <= w_target;
        r_resp_pc  <= w_target;
        r_drop     <= r_outst - CW'(imem_rvalid);
      end else begin
        if (w_grant)   r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_push)    r_resp_pc  <= r_resp_pc + 32'd4;
        if (w_discard) r_drop     <= r_drop - CW'(1);
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_flushed;
  logic [31:0] r_perf_starved;

  // Saturating event counters for pops, flushes and starved cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_perf_fetched <= '0;
      r_perf_flushed <= '0;
      r_perf_starved <= '0;
    end else begin
      r_perf_fetched <= sat_inc32(r_perf_fetched, w_pop);
      r_perf_flushed <= sat_inc32(r_perf_flushed, redirect);
      r_perf_starved <= sat_inc32(r_perf_starved,
                                  ~instr_valid & ~stall);
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_flushed = r_perf_flushed;
  assign perf_starved = r_perf_starved;
`endif

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// tb_fetch_prefetch_buffer: directed and random stimulus against a
// queue-level model of memory, buffered instructions and fetch PC.
module tb_fetch_prefetch_buffer;
  import fetch_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
  logic [31:0] perf_starved;
  int          pf, pl, ps;
`endif

  always #5 clk = ~clk;

  fetch_prefetch_buffer #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_flushed (perf_flushed),
    .perf_starved (perf_starved)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    int          ready;
    int          ep;
  } req_t;

  req_t         mq[$];
  fetch_entry_t fq[$];
  logic [31:0]  m_fpc;
  int           epoch;
  int           cyc;
  int           n_chk;
  int           n_fail;

  logic        d_rst, d_stall, d_redir;
  logic [31:0] d_target;
  int          gnt_mode, lat_lo, lat_hi;

  logic        s_req, s_valid;
  logic [31:0] s_addr, s_instr, s_pc;
  logic        e_req, e_valid, rv, gn;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h3C5A_0F11;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic step();
    req_t r;
    @(negedge clk);
    rst         = d_rst;
    stall       = d_stall;
    redirect    = d_redir;
    redirect_pc = d_target;
    rv = 1'b0;
    if (d_rst && mq.size() > 0) begin
      if (mq[0].ready <= cyc) rv = 1'b1;
    end
    imem_rvalid = rv;
    if (rv) imem_rdata = mem_word(mq[0].addr);
    else    imem_rdata = $urandom;
    case (gnt_mode)
      0:       gn = 1'b1;
      1:       gn = ($urandom_range(9) < 7);
      default: gn = 1'b0;
    endcase
    imem_gnt = gn;
    #1;
    e_req   = d_rst && !d_redir && (fq.size() + mq.size() < DEPTH);
    e_valid = d_rst && fq.size() > 0;
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_valid = instr_valid;
    s_instr = instr;
    s_pc    = instr_pc;
    chk("imem_req", s_req, e_req);
    if (e_req) chk("imem_addr", s_addr, m_fpc);
    chk("instr_valid", s_valid, e_valid);
    chk("instr", s_instr, e_valid ? fq[0].instr : 32'h0);
    chk("instr_pc", s_pc, e_valid ? fq[0].pc : 32'h0);
`ifdef FETCH_PERF_EN
    chk("perf_fetched", perf_fetched, pf);
    chk("perf_flushed", perf_flushed, pl);
    chk("perf_starved", perf_starved, ps);
`endif
    @(posedge clk);
    if (!d_rst) begin
      mq.delete();
      fq.delete();
      m_fpc = RESET_PC;
      epoch++;
`ifdef FETCH_PERF_EN
      pf = 0; pl = 0; ps = 0;
`endif
    end else begin
`ifdef FETCH_PERF_EN
      if (e_valid && !d_stall && !d_redir) pf++;
      if (d_redir) pl++;
      if (!e_valid && !d_stall) ps++;
`endif
      if (d_redir) begin
        fq.delete();
        m_fpc = {d_target[31:2], 2'b00};
        epoch++;
        if (rv) mq.delete(0);
      end else begin
        if (e_valid && !d_stall) fq.delete(0);
        if (rv) begin
          r = mq.pop_front();
          if (r.ep == epoch)
            fq.push_back('{instr: mem_word(r.addr), pc: r.addr});
        end
      end
      if (e_req && gn) begin
        mq.push_back('{addr: m_fpc,
                       ready: cyc + int'($urandom_range(lat_hi, lat_lo)),
                       ep: epoch});
        m_fpc = m_fpc + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic pulse_reset();
    d_rst = 1'b0;
    step();
    d_rst = 1'b1;
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0; epoch = 0; m_fpc = RESET_PC;
    d_rst = 1'b0; d_stall = 1'b0; d_redir = 1'b0; d_target = '0;
    gnt_mode = 0; lat_lo = 1; lat_hi = 1;
`ifdef FETCH_PERF_EN
    pf = 0; pl = 0; ps = 0;
`endif
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;

    // reset and streaming
    repeat (2) begin
      step();
      chk("rst_req", s_req, 0);
      chk("rst_valid", s_valid, 0);
      chk("rst_instr", s_instr, 0);
    end
    d_rst = 1'b1;
    step();
    chk("first_req", s_req, 1);
    chk("first_addr", s_addr, 32'h0);
    chk("first_valid", s_valid, 0);
    step();
    chk("startup_valid", s_valid, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stream_valid", s_valid, 1);
      chk("stream_pc", s_pc, 32'(i * 4));
      chk("stream_instr", s_instr, mem_word(32'(i * 4)));
    end

    // backpressure
    pulse_reset();
    d_stall = 1'b1;
    repeat (10) step();
    chk("bp_req", s_req, 0);
    chk("bp_valid", s_valid, 1);
    chk("bp_head", s_pc, 32'h0);
    d_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("drain_pc", s_pc, 32'(i * 4));
    end

    // redirect with two responses in flight
    pulse_reset();
    lat_lo = 3; lat_hi = 3;
    step();
    step();
    gnt_mode = 2; d_redir = 1'b1; d_target = 32'h100;
    step();
    chk("redir_req", s_req, 0);
    d_redir = 1'b0; gnt_mode = 0;
    step();
    chk("redir_addr", s_addr, 32'h100);
    chk("redir_drop1", s_valid, 0);
    step();
    chk("redir_drop2", s_valid, 0);
    step();
    step();
    step();
    chk("redir_pc0", s_pc, 32'h100);
    step();
    chk("redir_pc1", s_pc, 32'h104);

    // redirect coinciding with a response, unaligned target
    pulse_reset();
    lat_lo = 1; lat_hi = 1;
    step();
    d_redir = 1'b1; d_target = 32'h203;
    step();
    d_redir = 1'b0;
    step();
    chk("align_req", s_req, 1);
    chk("align_addr", s_addr, 32'h200);
    step();
    chk("same_cyc_drop", s_valid, 0);
    step();
    chk("align_pc", s_pc, 32'h200);

    // reset with three requests outstanding
    pulse_reset();
    lat_lo = 4; lat_hi = 4;
    repeat (3) step();
    d_rst = 1'b0;
    step();
    chk("midrst_req", s_req, 0);
    d_rst = 1'b1;
    step();
    chk("midrst_req1", s_req, 1);
    chk("midrst_addr", s_addr, RESET_PC);
    chk("midrst_valid", s_valid, 0);
`ifdef FETCH_PERF_EN
    chk("perf_clr_f", perf_fetched, 0);
    chk("perf_clr_l", perf_flushed, 0);
    chk("perf_clr_s", perf_starved, 0);
`endif
    repeat (8) step();

    // random traffic
    gnt_mode = 1; lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 4000; i++) begin
      d_stall = ($urandom_range(99) < (((i / 500) % 2 == 1) ? 85 : 30));
      d_redir = ($urandom_range(99) < 6);
      if ($urandom_range(3) == 0)
        d_target = 32'hFFFF_FFF0 | 32'($urandom_range(15));
      else
        d_target = $urandom;
      d_rst = !($urandom_range(999) < 5);
      step();
    end
    d_rst = 1'b1; d_redir = 1'b0; d_stall = 1'b0;
    repeat (10) step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
